// File: rtl/ark_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ark_stream_if : valid/ready bus for the AddRoundKey stream stage      |
// | Optional out_parity present when ARK_PARITY_EN is defined. Rev 1.0    |
// +----------------------------------------------------------------------+
interface ark_stream_if #(
  parameter int DATA_W = 128,
  parameter int RND_W  = 4
) ();
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_key;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RND_W-1:0]  out_round;
  logic              out_last;
  logic              busy;
`ifdef ARK_PARITY_EN
  logic [DATA_W/8-1:0] out_parity;

  modport slave (
    input  start, in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_round, out_last, busy, out_parity
  );
  modport master (
    output start, in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_last, busy, out_parity
  );
`else
  modport slave (
    input  start, in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_round, out_last, busy
  );
  modport master (
    output start, in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_last, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ark_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ark_stream : streaming AES AddRoundKey with 2-entry skid buffer and   |
// | round tagging. Macro ARK_PARITY_EN adds per-byte parity. Rev 1.0      |
// +----------------------------------------------------------------------+
module ark_stream #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ark_stream_if.slave bus
);
  localparam logic [RND_W-1:0] c_last_round = RND_W'(NUM_ROUNDS);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [RND_W-1:0]  r_out_round;
  logic              r_out_last;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [RND_W-1:0]  r_skid_round;
  logic              r_skid_last;
  logic [RND_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_out_open;
  logic [RND_W-1:0]  w_tag;
  logic              w_last;
  logic [DATA_W-1:0] w_data;
  logic [RND_W-1:0]  w_cnt_next;

  // in_ready depends only on skid occupancy, so it never follows out_ready combinationally
  assign w_accept   = bus.in_valid & ~r_skid_valid;
  assign w_out_open = ~r_out_valid | bus.out_ready;
  assign w_tag      = bus.start ? '0 : r_cnt;
  assign w_last     = (w_tag == c_last_round);
  assign w_data     = bus.in_data ^ bus.in_key;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_accept)
      w_cnt_next = w_last ? '0 : w_tag + RND_W'(1);
    else if (bus.start)
      w_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Output register: skid has priority so ordering is preserved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_round <= '0;
      r_out_last  <= 1'b0;
    end else if (w_out_open) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_out_round <= r_skid_round;
        r_out_last  <= r_skid_last;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_round <= w_tag;
        r_out_last  <= w_last;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_round <= '0;
      r_skid_last  <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_out_open)
        r_skid_valid <= 1'b0;
    end else if (w_accept && !w_out_open) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_data;
      r_skid_round <= w_tag;
      r_skid_last  <= w_last;
    end
  end

`ifdef ARK_PARITY_EN
  localparam int c_nbytes = DATA_W / 8;

  logic [c_nbytes-1:0] w_par;
  logic [c_nbytes-1:0] r_out_par;
  logic [c_nbytes-1:0] r_skid_par;

  // Bit i covers byte i, where byte 0 is the most significant byte
  for (genvar gi = 0; gi < c_nbytes; gi++) begin : g_par
    assign w_par[gi] = ^w_data[DATA_W-1-8*gi -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= '0;
    end else if (w_out_open) begin
      if (r_skid_valid)
        r_out_par <= r_skid_par;
      else if (w_accept)
        r_out_par <= w_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_par <= '0;
    end else if (!r_skid_valid && w_accept && !w_out_open) begin
      r_skid_par <= w_par;
    end
  end

  assign bus.out_parity = r_out_par;
`endif

  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_round = r_out_round;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_out_valid | r_skid_valid | (r_cnt != '0);
endmodule
`default_nettype wire

// File: doc/ark_stream.md
Name: ark_stream

Overview:
- Parametrised, streaming AddRoundKey stage for the AES datapath: XORs a state block with a round key and tracks the round index.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains one block per cycle under back-pressure.
- Sits between the MixColumns/ShiftRows stage and the next round input; tags each result with its round number and a last-round flag for the round controller.

Parameters:
- DATA_W, 128, state/key width in bits; multiple of 8, at least 8.
- NUM_ROUNDS, 10, last round index; 10, 12 or 14 for AES-128/192/256.
- RND_W, 4, width of round index; must satisfy 2^RND_W > NUM_ROUNDS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous pulse; clears round counter, begins new block
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept beat
- in_data  in  DATA_W  state; byte 0 = bits [DATA_W-1 -: 8]
- in_key  in  DATA_W  round key, same byte order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  in_data ^ in_key
- out_round  out  RND_W  round index of this result
- out_last  out  1  out_round == NUM_ROUNDS
- busy  out  1  any entry held or counter non-zero

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_round=0, out_last=0, in_ready=1, busy=0; counter=0; both skid entries empty.
- Accept: in_valid & in_ready on a clk edge. Output transfer: out_valid & out_ready on a clk edge.
- Latency: 1 cycle. An accepted beat appears on out_* on the next cycle if the output register is empty or draining.
- Datapath: out_data = bytewise XOR, i.e. full-width XOR. No carries; width is preserved.
- Buffering: output register plus one skid register.
  - in_ready = skid entry empty. in_ready is registered, never combinational from out_ready.
  - Output stalled and input accepted: beat goes to skid; in_ready drops next cycle.
  - Output drains: skid moves to output register; in_ready rises next cycle.
  - No beat is lost or duplicated. Order is preserved.
- Round counter:
  - Each accepted beat is tagged with the current counter value, then the counter increments.
  - At NUM_ROUNDS the counter wraps to 0 after accept. out_last travels with the beat.
- start:
  - Clears the counter the same cycle it is sampled.
  - start and accept in the same cycle: the beat is tagged round 0 and the counter becomes 1.
  - start does not flush buffered beats; they keep their original tags.
- Simultaneous input accept and output transfer with skid empty: output register reloads directly. Throughput is 1 beat/cycle.
- out_valid low: out_data, out_round and out_last hold their last value. Output is stable while out_valid & !out_ready.
- Reset mid-operation: all buffered beats are discarded immediately; outputs return to reset values.
- busy = out_valid | skid_valid | (counter != 0).

Optional Feature:
ARK_PARITY_EN
- Defined: adds output out_parity [DATA_W/8] carried with each beat.
  - Bit i = XOR of the 8 bits of out_data byte i, computed at accept time and registered alongside the data.
  - Reset value 0.
- Undefined: port absent; no parity logic.

Test Plan:
- FIPS-197 round 0: start pulse, then in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c -> next cycle out_data=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
- Stream of 11 beats, out_ready=1: out_round 0..10, out_last=1 only on round 10, one result per cycle; a 12th beat gets round 0.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> two beats held, in_ready=0 after the second. out_ready=1 -> both emerge in order, no loss or duplication, in_ready returns to 1.
- start asserted together with an accepted beat while counter=5 -> that beat has out_round=0 and the next beat has out_round=1.
- rst_n low asynchronously mid-stall with both entries full -> out_valid=0, in_ready=1, busy=0 immediately, without waiting for a clock edge.
- ARK_PARITY_EN defined: in_data=0, in_key=01ff...ff -> out_parity[0]=1 (byte 0 = 01), out_parity[1..15]=0 (bytes ff).
